mem_param: RTL and testbench
============================

Name: mem_param

Overview:
- Next-generation synchronous single-port memory: parametrised width/depth, per-byte write enables, configurable read latency.
- Hardware clear-on-reset sequencer, busy indication, sticky protocol-error flag.
- Sits behind the bus-side driver/testbench as the storage slave.
- Replaces the fixed 8x32 memory; read-and-write in the same cycle is now detected and flagged rather than merely forbidden.

Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W words.
- READ_LAT, 1: read latency in cycles; legal values 1 or 2 (elaboration error otherwise).
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents undefined, no clear phase.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- read  input  1  read request.
- write  input  1  write request.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- be  input  DATA_W/8  byte enables; bit i covers data_in[8i+7:8i].
- data_out  output  DATA_W  read data.
- rd_valid  output  1  one-cycle pulse, data_out valid.
- busy  output  1  clear sequence running; requests ignored.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0 at posedge): data_out=0, rd_valid=0, err=0, read pipeline flushed, clear counter=0. State=INIT and busy=1 if CLEAR_ON_RESET=1; else state=IDLE and busy=0.
- FSM states: INIT, IDLE.
- INIT: each posedge writes 0 to memory[cnt] and increments cnt. Posedge with cnt==DEPTH-1 writes the last word and moves to IDLE. busy=1 for exactly DEPTH cycles after reset is released, then 0.
- Reset asserted mid-INIT restarts the clear at word 0.
- IDLE, write=1 and read=0: memory[addr] byte lane i <= data_in lane i for every be[i]=1; other lanes unchanged. Commits at the sampling posedge, no delay. be=0 is a legal no-op.
- IDLE, read=1 and write=0, sampled at posedge N:
  - READ_LAT=1: data_out=memory[addr] and rd_valid=1 after posedge N.
  - READ_LAT=2: same outputs after posedge N+1.
  - rd_valid is high for one cycle per read.
  - Back-to-back reads give back-to-back rd_valid pulses, full throughput.
- Read-after-write: a read sampled one cycle after a write to the same address returns the new data.
- data_out holds its last value when rd_valid=0.
- read=1 and write=1 at the same posedge: no memory access, no rd_valid, err<=1.
- read or write asserted while busy=1: request ignored, err<=1.
- err clears only on reset.
- Address range is always in bounds (DEPTH = 2**ADDR_W); the address wraps naturally.
- Reset mid-read kills pending rd_valid; data_out returns to 0.

Decomposition:
- Package mem_pkg:
  - typedef enum logic {INIT, IDLE} mem_state_e
  - localparam BYTE_W=8
  - function for the byte-lane count
- One sub-module mem_rd_pipe: parametrised READ_LAT-stage delay line for {valid, data}, synchronous active-low reset clearing all stages.
- Storage array, byte-lane write loop and FSM stay in mem_param.

Test Plan:
- Clear: CLEAR_ON_RESET=1, ADDR_W=5, rst_n low 2 cycles then high -> busy high exactly 32 cycles; subsequent reads of addr 0..31 all return 0.
- Byte enables: DATA_W=32, write 0xAABBCCDD with be=4'hF to addr 3, then 0x11223344 with be=4'b0101 -> read addr 3 returns 0xAA22CC44.
- Latency: READ_LAT=2, reads at cycles 10, 11, 12 to addrs 1, 2, 3 -> rd_valid high at cycles 12, 13, 14 with matching data; READ_LAT=1 -> cycles 11, 12, 13.
- Collision: read=1 and write=1 to addr 5 with data_in=0x5A -> err=1, no rd_valid, addr 5 unchanged on later read; err stays 1 until reset.
- Busy access: write to addr 0 during INIT cycle 4 -> err=1; addr 0 reads 0 after the clear completes.
- Reset mid-op: assert rst_n=0 the cycle after a read issue with READ_LAT=2 -> no rd_valid pulse, data_out=0, clear restarts from word 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised single-port memory.
//   mem_state_e : clear-sequencer state (INIT = zeroing words, IDLE = serving)
//   BYTE_W      : width of one byte lane
//   num_lanes() : byte-lane count for a given word width
package mem_pkg;
  typedef enum logic {INIT, IDLE} mem_state_e;

  localparam int BYTE_W = 8;

  function automatic int num_lanes(input int data_w);
    return data_w / BYTE_W;
  endfunction
endpackage

// File: rtl/mem_param_if.sv
// Bus between the requesting driver (master) and the memory (slave).
//   read/write/addr/data_in/be : request, driven by master
//   data_out/rd_valid          : read response
//   busy/err                   : clear-in-progress and sticky protocol error
interface mem_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output read, write, addr, data_in, be,
    input  data_out, rd_valid, busy, err
  );

  modport slave (
    input  read, write, addr, data_in, be,
    output data_out, rd_valid, busy, err
  );
endinterface

// File: rtl/mem_rd_pipe.sv
// STAGES-deep delay line for read {valid, data}.
//   vld_i/data_i : read issued this cycle and the word read from the array
//   vld_o/data_o : response after STAGES clocks; data only advances with
//                  valid, so data_o holds the last returned word.
module mem_rd_pipe #(
  parameter int STAGES = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] data_pipe;

  assign vld_pipe[0]  = vld_i;
  assign data_pipe[0] = data_i;

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_pipe[s]  <= 1'b0;
        data_pipe[s] <= '0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe[STAGES];
  assign data_o = data_pipe[STAGES];
endmodule

// File: rtl/mem_param.sv
// Single-port memory, DEPTH = 2**ADDR_W words of DATA_W bits.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_param_if slave (request in, read response/status out)
// Byte-enabled writes commit at the sampling edge; reads return after
// READ_LAT clocks. After reset an optional sequencer zeroes every word,
// holding busy; any request during that time, or read+write together,
// is dropped and sets the sticky err flag.
module mem_param
  import mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 5,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_param_if.slave bus
);
  localparam int LANES = num_lanes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("mem_param: READ_LAT must be 1 or 2");
  end
  if (DATA_W % BYTE_W != 0) begin : g_bad_w
    $error("mem_param: DATA_W must be a multiple of 8");
  end

  logic [LANES-1:0][BYTE_W-1:0] mem_q [DEPTH];

  mem_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              err_q;

  logic in_idle, collide, wr_fire, rd_fire, clr_we;

  assign in_idle = (state_q == IDLE);
  assign collide = bus.read & bus.write;
  // rst_n gating keeps a request presented during reset from touching the array
  assign wr_fire = rst_n & in_idle & bus.write & ~bus.read;
  assign rd_fire = rst_n & in_idle & bus.read & ~bus.write;
  assign clr_we  = rst_n & (state_q == INIT);

  // Storage: no reset on the array itself; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < LANES; i++)
        if (bus.be[i]) mem_q[bus.addr][i] <= bus.data_in[i*BYTE_W +: BYTE_W];
    end
  end

  // Clear sequencer and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
      busy_q  <= (CLEAR_ON_RESET != 0);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (collide || (busy_q && (bus.read || bus.write))) err_q <= 1'b1;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  mem_rd_pipe #(
    .STAGES (READ_LAT),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (rd_fire),
    .data_i (mem_q[bus.addr]),
    .vld_o  (bus.rd_valid),
    .data_o (bus.data_out)
  );

  assign bus.busy = busy_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_mem_param.sv
module tb_mem_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: READ_LAT=2, B: READ_LAT=1, same inputs
  mem_param_if #(.DATA_W(32), .ADDR_W(5)) bA ();
  mem_param_if #(.DATA_W(32), .ADDR_W(5)) bB ();

  assign bB.read    = bA.read;
  assign bB.write   = bA.write;
  assign bB.addr    = bA.addr;
  assign bB.data_in = bA.data_in;
  assign bB.be      = bA.be;

  mem_param #(.DATA_W(32), .ADDR_W(5), .READ_LAT(2), .CLEAR_ON_RESET(1))
    dutA (.clk(clk), .rst_n(rst_n), .bus(bA));
  mem_param #(.DATA_W(32), .ADDR_W(5), .READ_LAT(1), .CLEAR_ON_RESET(1))
    dutB (.clk(clk), .rst_n(rst_n), .bus(bB));

  int passed = 0;
  int total  = 0;
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    bA.write = 1'b1; bA.addr = a; bA.data_in = d; bA.be = b;
    tick();
    bA.write = 1'b0;
  endtask

  // single read: B responds after the issue edge, A one edge later
  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    bA.read = 1'b1; bA.addr = a;
    tick();
    bA.read = 1'b0;
    chk("rdB_vld", {31'b0, bB.rd_valid}, 32'd1);
    chk("rdB_data", bB.data_out, exp);
    chk("rdA_vld_early", {31'b0, bA.rd_valid}, 32'd0);
    tick();
    chk("rdA_vld", {31'b0, bA.rd_valid}, 32'd1);
    chk("rdA_data", bA.data_out, exp);
    chk("rdB_vld_pulse", {31'b0, bB.rd_valid}, 32'd0);
    chk("rdB_hold", bB.data_out, exp);
  endtask

  // count cycles with busy high, bounded
  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (bA.busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    bA.read = 0; bA.write = 0; bA.addr = 0; bA.data_in = 0; bA.be = 0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busyA", {31'b0, bA.busy}, 32'd1);
    chk("rst_busyB", {31'b0, bB.busy}, 32'd1);
    chk("rst_vldA", {31'b0, bA.rd_valid}, 32'd0);
    chk("rst_doutA", bA.data_out, 32'd0);
    chk("rst_errA", {31'b0, bA.err}, 32'd0);

    // clear sequence with a write attempted in INIT cycle 4
    rst_n = 1'b1;
    n = 0;
    while (bA.busy === 1'b1 && n < 200) begin
      n++;
      bA.write   = (n == 4);
      bA.addr    = 5'd0;
      bA.data_in = 32'hFFFF_FFFF;
      bA.be      = 4'hF;
      tick();
    end
    bA.write = 1'b0;
    chk("clear_len", n, 32'd32);
    chk("busy_errA", {31'b0, bA.err}, 32'd1);
    chk("busy_errB", {31'b0, bB.err}, 32'd1);
    chk("busyB_done", {31'b0, bB.busy}, 32'd0);
    for (int i = 0; i < 32; i++) rd(5'(i), 32'd0);

    // fresh reset clears err
    rst_n = 1'b0;
    tick(); tick();
    chk("rst2_errA", {31'b0, bA.err}, 32'd0);
    rst_n = 1'b1;
    wait_clear(n);
    chk("clear2_len", n, 32'd32);

    // byte enables, be=0 no-op, read-after-write
    wr(5'd3, 32'hAABB_CCDD, 4'hF);
    wr(5'd3, 32'h1122_3344, 4'b0101);
    rd(5'd3, 32'hAA22_CC44);
    wr(5'd3, 32'hFFFF_FFFF, 4'h0);
    rd(5'd3, 32'hAA22_CC44);
    wr(5'd7, 32'h1234_5678, 4'hF);
    rd(5'd7, 32'h1234_5678);
    wr(5'd31, 32'hDEAD_BEEF, 4'b1000);
    rd(5'd31, 32'hDE00_0000);

    // back-to-back reads
    wr(5'd1, 32'h0000_0101, 4'hF);
    wr(5'd2, 32'h0000_0202, 4'hF);
    bA.read = 1'b1; bA.addr = 5'd1;
    tick();
    chk("b2b_B1_vld", {31'b0, bB.rd_valid}, 32'd1);
    chk("b2b_B1_dat", bB.data_out, 32'h0000_0101);
    chk("b2b_A_none", {31'b0, bA.rd_valid}, 32'd0);
    bA.addr = 5'd2;
    tick();
    chk("b2b_B2_dat", bB.data_out, 32'h0000_0202);
    chk("b2b_A1_vld", {31'b0, bA.rd_valid}, 32'd1);
    chk("b2b_A1_dat", bA.data_out, 32'h0000_0101);
    bA.addr = 5'd3;
    tick();
    bA.read = 1'b0;
    chk("b2b_B3_vld", {31'b0, bB.rd_valid}, 32'd1);
    chk("b2b_B3_dat", bB.data_out, 32'hAA22_CC44);
    chk("b2b_A2_dat", bA.data_out, 32'h0000_0202);
    tick();
    chk("b2b_B_off", {31'b0, bB.rd_valid}, 32'd0);
    chk("b2b_A3_vld", {31'b0, bA.rd_valid}, 32'd1);
    chk("b2b_A3_dat", bA.data_out, 32'hAA22_CC44);
    tick();
    chk("b2b_A_off", {31'b0, bA.rd_valid}, 32'd0);
    chk("b2b_A_hold", bA.data_out, 32'hAA22_CC44);

    // collision
    wr(5'd5, 32'h0000_00C3, 4'hF);
    chk("pre_coll_err", {31'b0, bA.err}, 32'd0);
    bA.read = 1'b1; bA.write = 1'b1; bA.addr = 5'd5; bA.data_in = 32'h5A; bA.be = 4'hF;
    tick();
    bA.read = 1'b0; bA.write = 1'b0;
    chk("coll_errA", {31'b0, bA.err}, 32'd1);
    chk("coll_errB", {31'b0, bB.err}, 32'd1);
    chk("coll_noB", {31'b0, bB.rd_valid}, 32'd0);
    tick();
    chk("coll_noA", {31'b0, bA.rd_valid}, 32'd0);
    rd(5'd5, 32'h0000_00C3);
    chk("err_sticky", {31'b0, bA.err}, 32'd1);

    // reset the cycle after a read issue
    bA.read = 1'b1; bA.addr = 5'd5;
    tick();
    bA.read = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_vldA", {31'b0, bA.rd_valid}, 32'd0);
    chk("mid_doutA", bA.data_out, 32'd0);
    chk("mid_doutB", bB.data_out, 32'd0);
    chk("mid_busy", {31'b0, bA.busy}, 32'd1);
    chk("mid_err", {31'b0, bA.err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_vldA_after", {31'b0, bA.rd_valid}, 32'd0);
    // reset again part-way through the clear: restart from word 0
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_clear(n);
    chk("restart_len", n, 32'd32);
    rd(5'd5, 32'd0);
    rd(5'd3, 32'd0);
    rd(5'd31, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
